mem_port_arbiter: RTL

//  Shares the single SAYEH memory port between the CPU controller (fetch/lda/sta strobes) and a DMA requester.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the SAYEH memory-port arbiter: FSM state encoding, grant IDs and a direction helper.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_MAX_DEF = 15;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arbState_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_e;

  // A requester asserting both strobes is treated as a writer.
  function automatic logic dirRead(input logic rd, input logic wr);
    return rd && !wr;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select for the memory port.
// ARB_ROUND_ROBIN_EN alternates ties against lastGrant; otherwise the CPU wins ties.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   cpuReq,
  input  logic   dmaReq,
  input  grant_e lastGrant,
  output grant_e grant
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = GNT_CPU;
    if (cpuReq && dmaReq) begin
      grant = (lastGrant == GNT_CPU) ? GNT_DMA : GNT_CPU;
    end else if (dmaReq) begin
      grant = GNT_DMA;
    end
  end
`else
  // Fixed priority keeps lastGrant on the port so both builds share one interface.
  logic unusedLastGrant;
  assign unusedLastGrant = lastGrant;

  always_comb begin
    grant = GNT_CPU;
    if (!cpuReq && dmaReq) begin
      grant = GNT_DMA;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the SAYEH memory port between CPU and DMA: arbitrate, one transfer, done pulse, watchdog abort.
// Build option: ARB_ROUND_ROBIN_EN selects alternating tie-break inside mem_arb_pick.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              ExternalReset_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dma_rd,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

  arbState_e         stateReg, stateNext;
  grant_e            winnerReg, winnerNext;
  grant_e            lastGrantReg, lastGrantNext;
  grant_e            pickGrant;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic              memRdReg, memRdNext;
  logic              memWrReg, memWrNext;
  logic [ADDR_W-1:0] memAddrReg, memAddrNext;
  logic [DATA_W-1:0] memWdataReg, memWdataNext;
  logic [DATA_W-1:0] cpuRdataReg, cpuRdataNext;
  logic [DATA_W-1:0] dmaRdataReg, dmaRdataNext;
  logic              cpuDoneReg, cpuDoneNext;
  logic              dmaDoneReg, dmaDoneNext;
  logic              timeoutReg, timeoutNext;
  logic              cpuReq, dmaReq;

  assign cpuReq = cpu_rd | cpu_wr;
  assign dmaReq = dma_rd | dma_wr;

  mem_arb_pick uPick (
    .cpuReq    (cpuReq),
    .dmaReq    (dmaReq),
    .lastGrant (lastGrantReg),
    .grant     (pickGrant)
  );

  always_ff @(posedge clk) begin
    if (!ExternalReset_n) begin
      stateReg     <= IDLE;
      winnerReg    <= GNT_CPU;
      lastGrantReg <= GNT_DMA;
      cntReg       <= '0;
      memRdReg     <= 1'b0;
      memWrReg     <= 1'b0;
      memAddrReg   <= '0;
      memWdataReg  <= '0;
      cpuRdataReg  <= '0;
      dmaRdataReg  <= '0;
      cpuDoneReg   <= 1'b0;
      dmaDoneReg   <= 1'b0;
      timeoutReg   <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      winnerReg    <= winnerNext;
      lastGrantReg <= lastGrantNext;
      cntReg       <= cntNext;
      memRdReg     <= memRdNext;
      memWrReg     <= memWrNext;
      memAddrReg   <= memAddrNext;
      memWdataReg  <= memWdataNext;
      cpuRdataReg  <= cpuRdataNext;
      dmaRdataReg  <= dmaRdataNext;
      cpuDoneReg   <= cpuDoneNext;
      dmaDoneReg   <= dmaDoneNext;
      timeoutReg   <= timeoutNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    winnerNext    = winnerReg;
    lastGrantNext = lastGrantReg;
    cntNext       = cntReg;
    memRdNext     = memRdReg;
    memWrNext     = memWrReg;
    memAddrNext   = memAddrReg;
    memWdataNext  = memWdataReg;
    cpuRdataNext  = cpuRdataReg;
    dmaRdataNext  = dmaRdataReg;
    cpuDoneNext   = 1'b0;
    dmaDoneNext   = 1'b0;
    timeoutNext   = 1'b0;

    case (stateReg)
      IDLE: begin
        if (cpuReq || dmaReq) begin
          winnerNext = pickGrant;
          cntNext    = '0;
          stateNext  = XFER;
          if (pickGrant == GNT_CPU) begin
            memAddrNext  = cpu_addr;
            memWdataNext = cpu_wdata;
            memWrNext    = cpu_wr;
            memRdNext    = dirRead(cpu_rd, cpu_wr);
          end else begin
            memAddrNext  = dma_addr;
            memWdataNext = dma_wdata;
            memWrNext    = dma_wr;
            memRdNext    = dirRead(dma_rd, dma_wr);
          end
        end
      end

      XFER: begin
        cntNext = cntReg + 1'b1;
        // mem_ready on the final allowed cycle still completes normally.
        if (mem_ready || (cntNext == WAIT_LIMIT)) begin
          memRdNext   = 1'b0;
          memWrNext   = 1'b0;
          stateNext   = DONE;
          timeoutNext = !mem_ready;
          cpuDoneNext = (winnerReg == GNT_CPU);
          dmaDoneNext = (winnerReg == GNT_DMA);
          if (memRdReg) begin
            if (winnerReg == GNT_CPU) begin
              cpuRdataNext = mem_ready ? mem_rdata : '0;
            end else begin
              dmaRdataNext = mem_ready ? mem_rdata : '0;
            end
          end
        end
      end

      DONE: begin
        lastGrantNext = winnerReg;
        stateNext     = IDLE;
      end

      default: begin
        stateNext = IDLE;
        memRdNext = 1'b0;
        memWrNext = 1'b0;
      end
    endcase
  end

  assign cpu_rdata   = cpuRdataReg;
  assign dma_rdata   = dmaRdataReg;
  assign cpu_done    = cpuDoneReg;
  assign dma_done    = dmaDoneReg;
  assign mem_rd      = memRdReg;
  assign mem_wr      = memWrReg;
  assign mem_addr    = memAddrReg;
  assign mem_wdata   = memWdataReg;
  assign timeout_err = timeoutReg;

endmodule
